// File: rtl/uart_rx_ext.sv
// UART receiver with AXI4-Stream output.
// Runtime parity (none/even/odd), one or two stop bits, 3-sample majority voting per bit,
// break detection and a parity flag carried on tuser.
module uart_rx_ext #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tuser,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  break_detect
);

    localparam logic [3:0] LastBit = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrk
    } state_e;

    state_e                state_q;

    // Synchroniser and edge-detect history, all preset to the idle-high line level
    logic                  sync1_q;
    logic                  rxs_q;
    logic                  rxs_prev_q;

    // Per-frame configuration captured at start detection
    logic [15:0]           ps_q;
    logic [1:0]            pmode_q;
    logic                  stop2_q;

    // Bit timing
    logic [15:0]           tick_cnt_q;
    logic [2:0]            tick_idx_q;
    logic                  samp3_q;
    logic                  samp4_q;

    // Frame accumulation
    logic [DATA_WIDTH-1:0] shift_q;
    logic [3:0]            bit_cnt_q;
    logic                  perr_q;
    logic                  nonzero_q;
    logic                  stop_bad_q;
    logic                  stop_idx_q;

    // Registered outputs
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tuser_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  frame_q;
    logic                  parity_q;
    logic                  break_q;

    logic                  tick;
    logic                  tick5;
    logic                  tick7;
    logic                  maj;
    logic                  par_en;
    logic                  par_odd;
    logic                  handshake;
    logic                  last_stop;
    logic                  stop_bad_now;
    logic                  perr_now;
    logic                  start_edge;
    logic [15:0]           ps_eff;

    // Tick decode, majority vote and frame-level decisions
    always_comb begin
        tick         = (tick_cnt_q == 16'd0);
        tick5        = tick && (tick_idx_q == 3'd5);
        tick7        = tick && (tick_idx_q == 3'd7);
        // Third vote is the live synchronised sample at tick 5
        maj          = (samp3_q & samp4_q) | (samp3_q & rxs_q) | (samp4_q & rxs_q);
        par_en       = (pmode_q == 2'b01) || (pmode_q == 2'b10);
        par_odd      = (pmode_q == 2'b10);
        handshake    = tvalid_q && output_axis_tready;
        last_stop    = !stop2_q || stop_idx_q;
        stop_bad_now = stop_bad_q || !maj;
        perr_now     = ((^shift_q) ^ maj) != par_odd;
        start_edge   = rxs_prev_q && !rxs_q;
        ps_eff       = (prescale == 16'd0) ? 16'd1 : prescale;
    end

    // Receive FSM with synchroniser, bit timing and output holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            ps_q       <= 16'd1;
            pmode_q    <= 2'b00;
            stop2_q    <= 1'b0;
            tick_cnt_q <= 16'd0;
            tick_idx_q <= 3'd0;
            samp3_q    <= 1'b0;
            samp4_q    <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= 4'd0;
            perr_q     <= 1'b0;
            nonzero_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            stop_idx_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
            parity_q   <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;

            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
            parity_q   <= 1'b0;
            break_q    <= 1'b0;

            if (handshake) begin
                tvalid_q <= 1'b0;
            end

            // Oversample tick generation while a frame is being timed
            if (state_q == StStart || state_q == StData ||
                state_q == StParity || state_q == StStop) begin
                if (tick) begin
                    tick_cnt_q <= ps_q - 16'd1;
                    tick_idx_q <= tick_idx_q + 3'd1;
                    if (tick_idx_q == 3'd3) begin
                        samp3_q <= rxs_q;
                    end
                    if (tick_idx_q == 3'd4) begin
                        samp4_q <= rxs_q;
                    end
                end else begin
                    tick_cnt_q <= tick_cnt_q - 16'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q    <= StStart;
                        busy_q     <= 1'b1;
                        ps_q       <= ps_eff;
                        pmode_q    <= parity_mode;
                        stop2_q    <= stop_bits;
                        tick_cnt_q <= ps_eff - 16'd1;
                        tick_idx_q <= 3'd0;
                        bit_cnt_q  <= 4'd0;
                        perr_q     <= 1'b0;
                        nonzero_q  <= 1'b0;
                        stop_bad_q <= 1'b0;
                        stop_idx_q <= 1'b0;
                    end
                end

                StStart: begin
                    if (tick5) begin
                        // A high majority in the start bit means the edge was noise
                        if (maj) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else if (tick7) begin
                        state_q <= StData;
                    end
                end

                StData: begin
                    if (tick5) begin
                        shift_q   <= {maj, shift_q[DATA_WIDTH-1:1]};
                        nonzero_q <= nonzero_q | maj;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end else if (tick7 && bit_cnt_q == LastBit) begin
                        state_q <= par_en ? StParity : StStop;
                    end
                end

                StParity: begin
                    if (tick5) begin
                        perr_q    <= perr_now;
                        nonzero_q <= nonzero_q | maj;
                    end else if (tick7) begin
                        state_q <= StStop;
                    end
                end

                StStop: begin
                    if (tick5) begin
                        if (!last_stop) begin
                            stop_bad_q <= stop_bad_now;
                        end else if (stop_bad_now && !nonzero_q) begin
                            // All-zero frame including stop: line is held in break
                            break_q <= 1'b1;
                            state_q <= StBrk;
                        end else if (stop_bad_now) begin
                            frame_q <= 1'b1;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            // Decide at tick 5 so the next start edge can be caught early
                            state_q  <= StIdle;
                            busy_q   <= 1'b0;
                            parity_q <= perr_q;
                            if (!tvalid_q || handshake) begin
                                tdata_q  <= shift_q;
                                tuser_q  <= perr_q;
                                tvalid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else if (tick7) begin
                        stop_idx_q <= 1'b1;
                    end
                end

                StBrk: begin
                    if (rxs_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign output_axis_tuser  = tuser_q;
    assign busy               = busy_q;
    assign overrun_error      = overrun_q;
    assign frame_error        = frame_q;
    assign parity_error       = parity_q;
    assign break_detect       = break_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: table of frames with expected outcomes, hand-written
// sequences for glitch/break/overrun/reset, and randomized frames against a frame-level model.
module tb_uart_rx_ext;

    localparam int KDeliver = 0;
    localparam int KFrame   = 1;
    localparam int KBreak   = 2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        rxd;
    logic [15:0] prescale;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        busy;
    logic        ov_err;
    logic        fr_err;
    logic        pa_err;
    logic        brk;

    uart_rx_ext #(
        .DATA_WIDTH(8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .output_axis_tdata (tdata),
        .output_axis_tvalid(tvalid),
        .output_axis_tready(tready),
        .output_axis_tuser (tuser),
        .rxd               (rxd),
        .prescale          (prescale),
        .parity_mode       (parity_mode),
        .stop_bits         (stop_bits),
        .busy              (busy),
        .overrun_error     (ov_err),
        .frame_error       (fr_err),
        .parity_error      (pa_err),
        .break_detect      (brk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  pmode;
        logic        stop2;
        logic [15:0] ps;
        logic        pflip;
        logic [1:0]  smask;
        int          exp_kind;
        logic        exp_tuser;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Observation state, written only by the monitor
    int         cyc = 0;
    int         rise_cyc = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         ov_cnt = 0;
    int         bk_cnt = 0;
    logic       tv_prev = 1'b0;
    logic [8:0] got_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tvalid && tready) got_q.push_back({tuser, tdata});
        if (fr_err) fe_cnt++;
        if (pa_err) pe_cnt++;
        if (ov_err) ov_cnt++;
        if (brk) bk_cnt++;
        if (tvalid && !tv_prev) rise_cyc = cyc;
        tv_prev = tvalid;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                                input logic [15:0] ps, input logic pf, input logic [1:0] sm,
                                input int kind, input logic tu);
        vec_t v;
        v.data = d; v.pmode = pm; v.stop2 = s2; v.ps = ps; v.pflip = pf; v.smask = sm;
        v.exp_kind = kind; v.exp_tuser = tu;
        return v;
    endfunction

    function automatic logic par_on(input vec_t v);
        return (v.pmode == 2'b01) || (v.pmode == 2'b10);
    endfunction

    // Parity bit put on the wire: correct for the mode, inverted when pflip is set
    function automatic logic sent_pbit(input vec_t v);
        logic p;
        p = (v.pmode == 2'b10) ? ~(^v.data) : (^v.data);
        return p ^ v.pflip;
    endfunction

    // Frame-level reference: outcome from the bits on the wire
    function automatic vec_t with_expect(input vec_t v);
        vec_t r;
        logic pb;
        logic stop_bad;
        int   ones;
        r = v;
        pb = par_on(v) ? sent_pbit(v) : 1'b0;
        ones = $countones(v.data) + int'(pb);
        stop_bad = v.smask[0] || (v.stop2 && v.smask[1]);
        if (stop_bad) r.exp_kind = ((v.data == 8'h00) && !pb) ? KBreak : KFrame;
        else r.exp_kind = KDeliver;
        r.exp_tuser = !stop_bad && par_on(v) && ((ones % 2) != ((v.pmode == 2'b10) ? 1 : 0));
        return r;
    endfunction

    // Called at posedge+1; holds the level for one bit time
    task automatic drive_bit(input logic b, input int unsigned p);
        rxd = b;
        repeat (8 * p) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n, input int unsigned p);
        for (int i = 0; i < n; i++) drive_bit(1'b1, p);
    endtask

    task automatic send_frame(input vec_t v);
        int unsigned p;
        p = (v.ps == 16'd0) ? 1 : int'(v.ps);
        prescale = v.ps;
        parity_mode = v.pmode;
        stop_bits = v.stop2;
        drive_bit(1'b0, p);
        // Config is captured at start; scramble it to prove it is ignored mid-frame
        prescale = 16'($urandom);
        parity_mode = 2'($urandom);
        stop_bits = 1'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(v.data[i], p);
        if (par_on(v)) drive_bit(sent_pbit(v), p);
        drive_bit(~v.smask[0], p);
        if (v.stop2) drive_bit(~v.smask[1], p);
        rxd = 1'b1;
    endtask

    task automatic run_frame(input string name, input vec_t v);
        int fe0, pe0, ov0, bk0, n0, nw;
        int unsigned p;
        logic [8:0] w;
        p = (v.ps == 16'd0) ? 1 : int'(v.ps);
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; bk0 = bk_cnt; n0 = got_q.size();
        send_frame(v);
        idle_bits(3, p);
        nw = got_q.size() - n0;
        check({name, ".words"}, nw, (v.exp_kind == KDeliver) ? 1 : 0);
        if (nw > 0) begin
            w = got_q[got_q.size() - 1];
            check({name, ".tdata"}, int'(w[7:0]), int'(v.data));
            check({name, ".tuser"}, int'(w[8]), int'(v.exp_tuser));
        end
        check({name, ".frame_error"}, fe_cnt - fe0, (v.exp_kind == KFrame) ? 1 : 0);
        check({name, ".parity_error"}, pe_cnt - pe0,
              (v.exp_kind == KDeliver && v.exp_tuser) ? 1 : 0);
        check({name, ".break"}, bk_cnt - bk0, (v.exp_kind == KBreak) ? 1 : 0);
        check({name, ".overrun"}, ov_cnt - ov0, 0);
        check({name, ".busy_idle"}, int'(busy), 0);
    endtask

    vec_t vecs[13];

    initial begin
        int start_cyc, d, n0, fe0, bk0, ov0, pe0, nb;
        vec_t v;

        vecs[0]  = mk(8'hA5, 2'b00, 1'b0, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0);
        vecs[1]  = mk(8'h07, 2'b01, 1'b0, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0);
        vecs[2]  = mk(8'h07, 2'b01, 1'b0, 16'd1, 1'b1, 2'b00, KDeliver, 1'b1);
        vecs[3]  = mk(8'h3C, 2'b00, 1'b0, 16'd1, 1'b0, 2'b01, KFrame,   1'b0);
        vecs[4]  = mk(8'h11, 2'b00, 1'b0, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0);
        vecs[5]  = mk(8'h5A, 2'b10, 1'b1, 16'd3, 1'b0, 2'b00, KDeliver, 1'b0);
        vecs[6]  = mk(8'h96, 2'b00, 1'b1, 16'd1, 1'b0, 2'b10, KFrame,   1'b0);
        vecs[7]  = mk(8'h00, 2'b00, 1'b0, 16'd2, 1'b0, 2'b01, KBreak,   1'b0);
        vecs[8]  = mk(8'hC3, 2'b11, 1'b0, 16'd2, 1'b0, 2'b00, KDeliver, 1'b0);
        vecs[9]  = mk(8'h00, 2'b01, 1'b1, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0);
        vecs[10] = mk(8'hFF, 2'b10, 1'b0, 16'd0, 1'b1, 2'b00, KDeliver, 1'b1);
        vecs[11] = mk(8'h5A, 2'b00, 1'b0, 16'd4, 1'b0, 2'b00, KDeliver, 1'b0);
        vecs[12] = mk(8'hC3, 2'b00, 1'b0, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0);

        rst_n = 1'b1; rxd = 1'b1; tready = 1'b1;
        prescale = 16'd1; parity_mode = 2'b00; stop_bits = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        check("reset_outputs", int'({tvalid, tdata, tuser, busy, ov_err, fr_err, pa_err, brk}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 at prescale 1, with start-edge-to-tvalid latency
        start_cyc = cyc;
        run_frame("v0", vecs[0]);
        d = rise_cyc - start_cyc;
        check("v0.latency_window", (d >= 75 && d <= 83) ? 1 : 0, 1);

        for (int i = 1; i <= 10; i++) run_frame($sformatf("v%0d", i), vecs[i]);

        // Short glitch: start check rejects it
        fe0 = fe_cnt; bk0 = bk_cnt; n0 = got_q.size();
        prescale = 16'd4; parity_mode = 2'b00; stop_bits = 1'b0;
        rxd = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rxd = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("glitch.busy_set", int'(busy), 1);
        repeat (30) begin @(posedge clk); #1; end
        check("glitch.busy_clear", int'(busy), 0);
        check("glitch.no_events", (fe_cnt - fe0) + (bk_cnt - bk0) + (got_q.size() - n0), 0);

        // Break: line low for 20 bit times
        rxd = 1'b0;
        repeat (640) begin @(posedge clk); #1; end
        check("break.pulses", bk_cnt - bk0, 1);
        check("break.busy_held", int'(busy), 1);
        check("break.no_frame_err", fe_cnt - fe0, 0);
        check("break.no_word", got_q.size() - n0, 0);
        rxd = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("break.busy_release", int'(busy), 0);
        idle_bits(2, 4);
        run_frame("after_break", vecs[11]);

        // Overrun: holding register full, second word dropped
        tready = 1'b0;
        ov0 = ov_cnt; pe0 = pe_cnt; n0 = got_q.size();
        send_frame(mk(8'h01, 2'b00, 1'b0, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0));
        idle_bits(3, 1);
        send_frame(mk(8'h02, 2'b00, 1'b0, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0));
        idle_bits(3, 1);
        check("ovr.pulses", ov_cnt - ov0, 1);
        check("ovr.tvalid_held", int'(tvalid), 1);
        check("ovr.tdata_kept", int'(tdata), 8'h01);
        check("ovr.no_parity_err", pe_cnt - pe0, 0);
        tready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr.tvalid_clear", int'(tvalid), 0);
        check("ovr.words", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("ovr.word", int'(got_q[n0]), 9'h001);

        // Mid-frame reset with a pending word in the holding register
        tready = 1'b0;
        send_frame(mk(8'h33, 2'b00, 1'b0, 16'd1, 1'b0, 2'b00, KDeliver, 1'b0));
        idle_bits(3, 1);
        check("rst.pending_word", int'(tvalid), 1);
        nb = got_q.size();
        prescale = 16'd2;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 2);
        drive_bit(1'b0, 2);
        check("rst.busy_before", int'(busy), 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst.outputs_async", int'({tvalid, tdata, tuser, busy, ov_err, fr_err, pa_err, brk}),
              0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rxd = 1'b1;
        tready = 1'b1;
        idle_bits(3, 2);
        run_frame("after_reset", vecs[12]);
        check("rst.only_new_word", got_q.size() - nb, 1);

        // Randomized frames against the frame-level model
        for (int i = 0; i < 40; i++) begin
            v.data  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) v.data = 8'h00;
            v.pmode = 2'($urandom);
            v.stop2 = 1'($urandom);
            v.ps    = 16'($urandom_range(0, 3));
            v.pflip = ($urandom_range(0, 3) == 0);
            v.smask = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v = with_expect(v);
            run_frame($sformatf("rnd%0d", i), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
